ghost_move_sequencer: RTL and testbench

- Upstream driver for one ghost's behaviour engine.
- Holds the ghost's authoritative tile position and divides the frame tick down to a move rate.
- On each due move, snapshots the ghost and Pac-Man positions, starts the behaviour engine with a start/done handshake, then commits the returned next position.
- One instance sits between the game-state/tick logic and each ghost behaviour block. Its `ghostPos` feeds the renderer and collision logic.

---
 rtl/ghost_move_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ghost_move_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_move_sequencer.sv
// ghost_move_sequencer
// Owns one ghost's committed tile position. Divides the frame tick down to a
// move rate and queues at most one move request. For each request it snapshots
// the ghost and Pac-Man positions, starts the behaviour engine with a
// start/done handshake, and commits the returned next position.
//
// Build option: define GHOST_TIMEOUT_EN to add a bounded wait for gh_done.
// This also adds the TIMEOUT_CYC parameter and a one-cycle `timeout` pulse
// output. Without the macro, WAIT holds until gh_done arrives.
module ghost_move_sequencer #(
    parameter logic [9:0]  START_POS = 10'd395,
    parameter int unsigned TICK_DIV  = 8
`ifdef GHOST_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1023
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [9:0] pacPos,
    input  logic       gh_ready,
    input  logic       gh_done,
    input  logic [9:0] gh_nextPos,
    output logic       gh_start,
    output logic [9:0] gh_currPos,
    output logic [9:0] gh_targetPos,
    output logic [9:0] ghostPos,
    output logic       moved,
    output logic       caught,
`ifdef GHOST_TIMEOUT_EN
    output logic       timeout,
`endif
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_t     state_r;
    logic [7:0] tick_cnt_r;
    logic       pending_r;
    logic       overrun_r;
    logic [9:0] ghost_pos_r;
    logic [9:0] curr_pos_r;
    logic [9:0] target_pos_r;
    logic       start_r;
    logic       moved_r;
    logic       caught_r;
    logic       tick_en_s;
    logic       due_s;
    logic       leave_idle_s;

`ifdef GHOST_TIMEOUT_EN
    // The FSM leaves WAIT on the edge that ends the last allowed cycle, so the
    // compare is against TIMEOUT_CYC-1 (the counter would reach TIMEOUT_CYC).
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYC - 1);
    logic [9:0] wait_cnt_r;
    logic       timeout_r;
    assign timeout = timeout_r;
`endif

    assign tick_en_s    = tick & enable;
    assign due_s        = tick_en_s && (tick_cnt_r == TICK_LAST);
    assign leave_idle_s = (state_r == ST_IDLE) && pending_r;

    assign gh_start     = start_r;
    assign gh_currPos   = curr_pos_r;
    assign gh_targetPos = target_pos_r;
    assign ghostPos     = ghost_pos_r;
    assign moved        = moved_r;
    assign caught       = caught_r;
    assign overrun      = overrun_r;

    // Frame-tick divider: counts enabled ticks, wraps and flags "due" on the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= 8'd0;
        end else if (due_s) begin
            tick_cnt_r <= 8'd0;
        end else if (tick_en_s) begin
            tick_cnt_r <= tick_cnt_r + 8'd1;
        end
    end

    // One-deep request slot; a due arriving while it is still occupied is dropped and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else if (due_s) begin
            // A due on the same edge the FSM consumes the slot simply refills it.
            pending_r <= 1'b1;
            if (pending_r && !leave_idle_s) begin
                overrun_r <= 1'b1;
            end
        end else if (leave_idle_s) begin
            pending_r <= 1'b0;
        end
    end

    // Move FSM: request, snapshot, start pulse, wait for the engine, commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            ghost_pos_r  <= START_POS;
            curr_pos_r   <= START_POS;
            target_pos_r <= 10'd0;
            start_r      <= 1'b0;
            moved_r      <= 1'b0;
`ifdef GHOST_TIMEOUT_EN
            wait_cnt_r   <= 10'd0;
            timeout_r    <= 1'b0;
`endif
        end else begin
            start_r <= 1'b0;
            moved_r <= 1'b0;
`ifdef GHOST_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (pending_r) begin
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Snapshots are taken on the cycle the engine is seen ready,
                    // so gh_targetPos reflects Pac-Man at the moment of issue.
                    if (gh_ready) begin
                        curr_pos_r   <= ghost_pos_r;
                        target_pos_r <= pacPos;
                        start_r      <= 1'b1;
                        state_r      <= ST_START;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT;
`ifdef GHOST_TIMEOUT_EN
                    wait_cnt_r <= 10'd0;
`endif
                end
                ST_WAIT: begin
                    // gh_done takes priority over an expiring wait.
                    if (gh_done) begin
                        ghost_pos_r <= gh_nextPos;
                        moved_r     <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
`ifdef GHOST_TIMEOUT_EN
                    else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 10'd1;
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Collision flag against the live Pac-Man position, one cycle behind ghostPos.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            caught_r <= 1'b0;
        end else begin
            caught_r <= (ghost_pos_r == pacPos);
        end
    end

endmodule

// File: tb/tb_ghost_move_sequencer.sv
`timescale 1ns/1ps
module tb_ghost_move_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [9:0] pacPos;
    logic       gh_ready;
    logic       gh_done;
    logic [9:0] gh_nextPos;
    logic       gh_start;
    logic [9:0] gh_currPos;
    logic [9:0] gh_targetPos;
    logic [9:0] ghostPos;
    logic       moved;
    logic       caught;
    logic       overrun;
`ifdef GHOST_TIMEOUT_EN
    logic       timeout;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] curr;
        logic [9:0] target;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [9:0] pac;
        logic [9:0] next;
        logic [9:0] exp_curr;
        logic       exp_caught;
    } vec_t;
    vec_t vecs[5];

    ghost_move_sequencer #(
        .START_POS(10'd395),
        .TICK_DIV(4)
`ifdef GHOST_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .tick(tick),
        .pacPos(pacPos),
        .gh_ready(gh_ready),
        .gh_done(gh_done),
        .gh_nextPos(gh_nextPos),
        .gh_start(gh_start),
        .gh_currPos(gh_currPos),
        .gh_targetPos(gh_targetPos),
        .ghostPos(ghostPos),
        .moved(moved),
        .caught(caught),
`ifdef GHOST_TIMEOUT_EN
        .timeout(timeout),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // n enabled tick pulses, one idle cycle between them; ends one cycle after the last tick
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < n - 1) begin
                step();
            end
        end
    endtask

    // steps until gh_start is seen, -1 if the bound expires
    task automatic wait_start(input int bound, output int steps);
        steps = 0;
        while (gh_start !== 1'b1 && steps < bound) begin
            step();
            steps++;
        end
        if (gh_start !== 1'b1) begin
            steps = -1;
        end
    endtask

    // called in the gh_start cycle: compare the snapshots with the scoreboard
    task automatic take_start();
        exp_t e;
        check_int("scoreboard_has_entry", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check10("gh_currPos", gh_currPos, e.curr);
            check10("gh_targetPos", gh_targetPos, e.target);
        end
    endtask

    // from the gh_start cycle: engine answers with next, check commit and pulse shape
    task automatic finish_move(input logic [9:0] next);
        step();
        check1("start_single_pulse", gh_start, 1'b0);
        gh_done    = 1'b1;
        gh_nextPos = next;
        step();
        gh_done = 1'b0;
        check10("ghostPos_commit", ghostPos, next);
        check1("moved_pulse", moved, 1'b1);
        step();
        check1("moved_clear", moved, 1'b0);
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0] = '{pac: 10'd100,  next: 10'd396,  exp_curr: 10'd395,  exp_caught: 1'b0};
        vecs[1] = '{pac: 10'd397,  next: 10'd397,  exp_curr: 10'd396,  exp_caught: 1'b1};
        vecs[2] = '{pac: 10'd0,    next: 10'd0,    exp_curr: 10'd397,  exp_caught: 1'b1};
        vecs[3] = '{pac: 10'd5,    next: 10'd1023, exp_curr: 10'd0,    exp_caught: 1'b0};
        vecs[4] = '{pac: 10'd1023, next: 10'd512,  exp_curr: 10'd1023, exp_caught: 1'b0};

        reset      = 1'b0;
        enable     = 1'b0;
        tick       = 1'b0;
        pacPos     = 10'd100;
        gh_ready   = 1'b0;
        gh_done    = 1'b0;
        gh_nextPos = 10'd0;

        // reset state
        repeat (3) step();
        check10("rst_ghostPos", ghostPos, 10'd395);
        check10("rst_currPos", gh_currPos, 10'd395);
        check10("rst_targetPos", gh_targetPos, 10'd0);
        check1("rst_gh_start", gh_start, 1'b0);
        check1("rst_caught", caught, 1'b0);
        check1("rst_overrun", overrun, 1'b0);
        check1("rst_moved", moved, 1'b0);
        reset    = 1'b1;
        enable   = 1'b1;
        gh_ready = 1'b1;
        step();

        // table of single moves with the engine always ready
        for (int k = 0; k < 5; k++) begin
            pacPos = vecs[k].pac;
            sb_q.push_back('{curr: vecs[k].exp_curr, target: vecs[k].pac});
            do_ticks(4);
            wait_start(40, lat);
            check_int("tick_to_start_latency", (lat < 0) ? -1 : lat + 1, 3);
            take_start();
            finish_move(vecs[k].next);
            check1("caught_after_move", caught, vecs[k].exp_caught);
        end

        // engine not ready for 20 cycles while Pac-Man moves
        gh_ready = 1'b0;
        pacPos   = 10'd100;
        sb_q.push_back('{curr: 10'd512, target: 10'd101});
        do_ticks(4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                pacPos = 10'd101;
            end
            step();
            if (gh_start === 1'b1) begin
                seen = 1'b1;
            end
        end
        check1("no_start_without_ready", seen, 1'b0);
        gh_ready = 1'b1;
        wait_start(10, lat);
        check_int("ready_to_start_latency", lat, 1);
        take_start();
        finish_move(10'd700);

        // stalled engine: one request queued, the next one overruns
        pacPos = 10'd200;
        sb_q.push_back('{curr: 10'd700, target: 10'd200});
        do_ticks(4);
        wait_start(40, lat);
        check_int("stall_first_start", (lat < 0) ? -1 : 1, 1);
        take_start();
        step();
        sb_q.push_back('{curr: 10'd800, target: 10'd200});
        do_ticks(4);
        check1("pending_no_overrun", overrun, 1'b0);
        do_ticks(4);
        check1("overrun_set", overrun, 1'b1);
        gh_done    = 1'b1;
        gh_nextPos = 10'd800;
        step();
        gh_done = 1'b0;
        check10("stall_commit", ghostPos, 10'd800);
        wait_start(40, lat);
        check_int("pending_start_latency", lat, 2);
        take_start();
        finish_move(10'd801);
        check1("overrun_sticky", overrun, 1'b1);
        repeat (3) step();
        check1("dropped_request_no_start", gh_start, 1'b0);

        // gh_done in IDLE is ignored
        gh_done    = 1'b1;
        gh_nextPos = 10'd77;
        step();
        gh_done = 1'b0;
        check10("idle_done_ignored", ghostPos, 10'd801);
        check1("idle_done_no_moved", moved, 1'b0);

        // disabled divider ignores ticks
        enable = 1'b0;
        do_ticks(8);
        wait_start(6, lat);
        check_int("no_start_when_disabled", lat, -1);
        enable = 1'b1;

        // reset asserted during WAIT abandons the move
        pacPos = 10'd300;
        sb_q.push_back('{curr: 10'd801, target: 10'd300});
        do_ticks(4);
        wait_start(40, lat);
        check_int("pre_reset_start", (lat < 0) ? -1 : 1, 1);
        take_start();
        step();
        #2;
        reset = 1'b0;
        #1;
        check10("async_rst_ghostPos", ghostPos, 10'd395);
        check1("async_rst_gh_start", gh_start, 1'b0);
        check1("async_rst_overrun", overrun, 1'b0);
        step();
        reset = 1'b1;
        step();
        gh_done    = 1'b1;
        gh_nextPos = 10'd5;
        step();
        gh_done = 1'b0;
        check10("late_done_after_reset", ghostPos, 10'd395);

`ifdef GHOST_TIMEOUT_EN
        // no gh_done: the wait expires and the move is dropped
        sb_q.push_back('{curr: 10'd395, target: 10'd300});
        do_ticks(4);
        wait_start(40, lat);
        take_start();
        step();
        lat = 0;
        while (timeout !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check_int("timeout_latency", lat, 16);
        check10("timeout_ghostPos", ghostPos, 10'd395);
        check1("timeout_no_moved", moved, 1'b0);
        step();
        check1("timeout_single_pulse", timeout, 1'b0);
        gh_done    = 1'b1;
        gh_nextPos = 10'd9;
        step();
        gh_done = 1'b0;
        check10("timeout_back_in_idle", ghostPos, 10'd395);
`endif

        check_int("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
